// File: rtl/mips_pkg.sv
// Shared types and widths for the register-file write-back path.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    // One buffered long-latency result waiting for the write port.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Starvation tracking for the FIFO head.
    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        STALL
    } wb_fsm_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular-buffer FIFO holding long-latency results until the write port is free.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        push_entry,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been
    // written, and leaving it out of reset keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Single producer of the register-file write port: ALU/MDU arbitration,
// head-starvation control and the pending-write scoreboard.
module regfile_writeback
    import mips_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_dest,
    input  logic [DATA_W-1:0]     mdu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  alu_stall,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     write_data
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_entry_t           head;
    wb_entry_t           push_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                pop;
    logic                blocked;
    wb_fsm_t             state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [NUM_REGS-1:0] busy_next;

    // Ready depends only on occupancy and reset, never on mdu_valid.
    assign mdu_ready  = reset && (fifo_count < CNT_W'(DEPTH));
    assign push       = mdu_valid && mdu_ready;
    assign pop        = !alu_valid && !fifo_empty;
    assign blocked    = alu_valid && !fifo_empty;
    assign push_entry = '{dest: mdu_dest, data: mdu_data};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_entry(push_entry),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Write port: the ALU always wins; $0 is consumed without a write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (alu_valid) begin
            reg_write  <= (alu_dest != '0);
            write_reg  <= alu_dest;
            write_data <= alu_data;
        end else if (pop) begin
            reg_write  <= (head.dest != '0);
            write_reg  <= head.dest;
            write_data <= head.data;
        end else begin
            reg_write  <= 1'b0;
        end
    end

    // Starvation FSM: after MAX_WAIT consecutive losses the ALU is held off.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            alu_stall <= 1'b0;
        end else if (!blocked) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            alu_stall <= 1'b0;
        end else begin
            case (state)
                IDLE, WAITING: begin
                    if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                        state     <= STALL;
                        wait_cnt  <= WAIT_W'(MAX_WAIT);
                        alu_stall <= 1'b1;
                    end else begin
                        state     <= WAITING;
                        wait_cnt  <= wait_cnt + 1'b1;
                        alu_stall <= 1'b0;
                    end
                end
                // ALU ignored the stall: it still wins, keep stalling.
                STALL: begin
                    state     <= STALL;
                    wait_cnt  <= WAIT_W'(MAX_WAIT);
                    alu_stall <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    wait_cnt  <= '0;
                    alu_stall <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        busy_next = busy;
        if (pop) busy_next[head.dest] = 1'b0;
        // Set after clear so a re-issue on the pop edge wins.
        if (issue_valid && issue_dest != '0) busy_next[issue_dest] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) busy <= '0;
        else        busy <= busy_next;
    end

    // Protocol checks; ignored by synthesis.
    assert property (@(posedge clk) disable iff (!reset) alu_stall |-> !alu_valid);
    assert property (@(posedge clk) disable iff (!reset) fifo_full |-> !mdu_ready);

endmodule
